// File: rtl/board_loader_if.sv
// Bundle of the board loader's byte-stream, cell-write and echo signals.
//   slave  : board_loader side (consumes rx bytes, produces writes/status/echo)
//   master : host side (drives rx bytes and tx_ready, observes the rest)
// Ports carried:
//   rx_data[8], rx_valid, rx_ready            UART receive handshake
//   wr_en, wr_addr[logWIDTH+logHEIGHT], wr_data  board cell write strobe
//   busy, done, error                         loader status
//   tx_data[8], tx_valid, tx_ready            echo to UART transmitter
interface board_loader_if #(
    parameter int unsigned logWIDTH  = 3,
    parameter int unsigned logHEIGHT = 3
) ();
    localparam int unsigned ADDR_W = logWIDTH + logHEIGHT;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, wr_en, wr_addr, wr_data, busy, done, error, tx_data, tx_valid
    );

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, wr_en, wr_addr, wr_data, busy, done, error, tx_data, tx_valid
    );
endinterface

// File: rtl/board_loader.sv
// Loads a 2^logWIDTH x 2^logHEIGHT life board from a UART byte stream.
// 'L' opens a load; cell characters write one cell each in row-major order,
// CR/LF zero-pads the rest of a partial row, ESC aborts, writing the last cell
// pulses done.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    board_loader_if.slave (rx handshake, cell write, status, echo)
// Optional feature: define BOARD_LOADER_ECHO_EN to echo every byte consumed
// while loading (and the opening 'L') on the tx channel, with rx back-pressure
// while an echo is outstanding.
module board_loader #(
    parameter int unsigned logWIDTH  = 3,
    parameter int unsigned logHEIGHT = 3
) (
    input  logic           clk,
    input  logic           reset,
    board_loader_if.slave  bus
);
    localparam int unsigned IDX_W = logWIDTH + logHEIGHT;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    localparam logic [7:0] CH_L     = 8'h4C;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_O     = 8'h4F;
    localparam logic [7:0] CH_LO    = 8'h6F;
    localparam logic [7:0] CH_ONE   = 8'h31;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rx_ready_q, rx_ready_d;
    logic             wr_en_q, wr_en_d;
    logic [IDX_W-1:0] wr_addr_q, wr_addr_d;
    logic             wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;

    // Byte decode of the incoming character.
    logic             accept_c;
    logic             is_one_c, is_zero_c, is_cell_c, is_eol_c, is_l_c, is_esc_c;
    logic             col_zero_c, idx_last_c;
    logic [IDX_W-1:0] idx_inc_c;

    assign accept_c   = bus.rx_valid & rx_ready_q;
    assign is_one_c   = (bus.rx_data == CH_O) | (bus.rx_data == CH_LO) | (bus.rx_data == CH_ONE);
    assign is_zero_c  = (bus.rx_data == CH_SPACE) | (bus.rx_data == CH_DOT) | (bus.rx_data == CH_ZERO);
    assign is_cell_c  = is_one_c | is_zero_c;
    assign is_eol_c   = (bus.rx_data == CH_CR) | (bus.rx_data == CH_LF);
    assign is_l_c     = (bus.rx_data == CH_L);
    assign is_esc_c   = (bus.rx_data == CH_ESC);
    assign col_zero_c = (idx_q[logWIDTH-1:0] == '0);
    assign idx_last_c = (idx_q == IDX_LAST);
    assign idx_inc_c  = idx_q + IDX_W'(1);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rx_ready_q <= rx_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Next state and cell index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && is_l_c) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    if (is_cell_c) begin
                        idx_d = idx_inc_c;
                        if (idx_last_c) begin
                            state_d = ST_IDLE;
                        end
                    end else if (is_l_c) begin
                        idx_d = '0;
                    end else if (is_esc_c) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else if (is_eol_c && !col_zero_c) begin
                        // CR/LF at column 0 falls through: CRLF advances one row.
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                idx_d = idx_inc_c;
                if (idx_last_c) begin
                    state_d = ST_IDLE;
                end else if (idx_inc_c[logWIDTH-1:0] == '0) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Registered-output next values: write strobe, status pulses, echo.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (accept_c) begin
                    if (is_cell_c) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q;
                        wr_data_d = is_one_c;
                        done_d    = idx_last_c;
                    end else if (is_esc_c) begin
                        error_d = 1'b1;
                    end else if (!is_l_c && !is_eol_c) begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_data_d = 1'b0;
                done_d    = idx_last_c;
            end
            default: begin
            end
        endcase

        busy_d = (state_d != ST_IDLE);

`ifdef BOARD_LOADER_ECHO_EN
        // Echo holds until tx_ready; rx is stalled while an echo is pending.
        tx_valid_d = tx_valid_q & ~bus.tx_ready;
        tx_data_d  = tx_data_q;
        if (accept_c && ((state_q == ST_LOAD) || ((state_q == ST_IDLE) && is_l_c))) begin
            tx_valid_d = 1'b1;
            tx_data_d  = bus.rx_data;
        end
        rx_ready_d = (state_d != ST_PAD) & ~tx_valid_d;
`else
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        rx_ready_d = (state_d != ST_PAD);
`endif
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_board_loader.sv
// Scoreboard bench for board_loader: a byte-level model queues expected
// writes/errors (and echoes when BOARD_LOADER_ECHO_EN is defined); a negedge
// monitor pops and compares whenever the DUT presents a write or error.
module tb_board_loader;
    localparam int unsigned LW = 3;
    localparam int unsigned LH = 3;
    localparam int NCELL = 64;
    localparam int W     = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    board_loader_if #(.logWIDTH(LW), .logHEIGHT(LH)) bus ();

    board_loader #(.logWIDTH(LW), .logHEIGHT(LH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit is_err;
        int addr;
        bit data;
        bit done;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] echo_q[$];
    int checks_total = 0;
    int checks_pass  = 0;
    int stall_cnt    = 0;
    int tx_bad       = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;
    int tx_hold      = 0;
    bit m_loading    = 0;
    int m_idx        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void push_wr(input int a, input bit d);
        exp_t e;
        e.is_err = 1'b0;
        e.addr   = a;
        e.data   = d;
        e.done   = (a == NCELL - 1);
        exp_q.push_back(e);
        if (a == NCELL - 1) m_loading = 1'b0;
    endfunction

    function automatic void push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.addr   = 0;
        e.data   = 1'b0;
        e.done   = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_echo(input logic [7:0] b);
`ifdef BOARD_LOADER_ECHO_EN
        echo_q.push_back(b);
`else
        if (b == 8'h00) tx_hold = tx_hold;
`endif
    endfunction

    // Reference model: consequence of one consumed byte.
    function automatic void model_byte(input logic [7:0] b);
        if (!m_loading) begin
            if (b == 8'h4C) begin
                m_loading = 1'b1;
                m_idx     = 0;
                push_echo(b);
            end
            return;
        end
        push_echo(b);
        case (b)
            8'h4F, 8'h6F, 8'h31: begin push_wr(m_idx, 1'b1); m_idx = (m_idx + 1) % NCELL; end
            8'h20, 8'h2E, 8'h30: begin push_wr(m_idx, 1'b0); m_idx = (m_idx + 1) % NCELL; end
            8'h0D, 8'h0A: begin
                while (m_idx % W != 0) begin
                    push_wr(m_idx, 1'b0);
                    m_idx = (m_idx + 1) % NCELL;
                end
            end
            8'h4C: m_idx = 0;
            8'h1B: begin push_err(); m_loading = 1'b0; end
            default: push_err();
        endcase
    endfunction

    // Monitor: scoreboard pops on write/error, tx handshake on this negedge.
    always @(negedge clk) begin : mon
        exp_t e;
        logic r;
        if (bus.wr_en) begin
            if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("wr_kind", 32'(e.is_err), 32'd0);
                check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                check("wr_data", 32'(bus.wr_data), 32'(e.data));
                check("wr_done", 32'(bus.done), 32'(e.done));
            end
        end else if (bus.done) begin
            check("done_without_wr", 32'd1, 32'd0);
        end
        if (bus.done) done_cnt++;
        if (bus.error) begin
            err_cnt++;
            if (exp_q.size() == 0) check("err_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("err_kind", 32'(e.is_err), 32'd1);
            end
        end
        if (bus.busy && !bus.rx_ready) stall_cnt++;
        r = (tx_hold > 0) ? 1'b0 : 1'(($urandom_range(0, 1)));
        if (tx_hold > 0) tx_hold--;
`ifdef BOARD_LOADER_ECHO_EN
        if (bus.tx_valid) check("rx_ready_while_tx", 32'(bus.rx_ready), 32'd0);
        if (bus.tx_valid && r) begin
            if (echo_q.size() == 0) check("echo_unexpected", 32'd1, 32'd0);
            else check("echo_data", 32'(bus.tx_data), 32'(echo_q.pop_front()));
        end
`else
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) tx_bad++;
`endif
        bus.tx_ready = r;
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                check("send_timeout", 32'd1, 32'd0);
                bus.rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_byte(b);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_dut(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        check("queue_after_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        echo_q.delete();
        m_loading = 1'b0;
        m_idx     = 0;
        reset     = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0;
        logic [7:0] b;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_wr_en",    32'(bus.wr_en),    32'd0);
        check("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        check("rst_wr_data",  32'(bus.wr_data),  32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_error",    32'(bus.error),    32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data",  32'(bus.tx_data),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rx_ready_after_reset", 32'(bus.rx_ready), 32'd1);

        // Alternating full board.
        d0 = done_cnt;
        send(8'h4C);
        check("busy_after_L", 32'(bus.busy), 32'd1);
        for (int i = 0; i < NCELL; i++) send((i % 2 == 0) ? 8'h4F : 8'h20);
        drain();
        check("alt_done_count", 32'(done_cnt - d0), 32'd1);
        check("alt_idle", 32'(bus.busy), 32'd0);

        // Short row with CRLF padding.
        d0 = done_cnt;
        stall_cnt = 0;
        send(8'h4C); send(8'h4F); send(8'h4F); send(8'h0D); send(8'h0A);
        for (int i = 0; i < 56; i++) send(8'h2E);
        drain();
        check("pad_done_count", 32'(done_cnt - d0), 32'd1);
`ifndef BOARD_LOADER_ECHO_EN
        check("pad_stall_cycles", 32'(stall_cnt), 32'd6);
`endif

        // Abort with ESC.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h4C);
        for (int i = 0; i < 5; i++) send(8'h31);
        send(8'h1B);
        drain();
        check("esc_busy", 32'(bus.busy), 32'd0);
        check("esc_no_done", 32'(done_cnt - d0), 32'd0);
        check("esc_err_count", 32'(err_cnt - e0), 32'd1);

        // Illegal byte mid-load.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h4C); send(8'h78);
        for (int i = 0; i < NCELL; i++) send(8'h30);
        drain();
        check("bad_err_count", 32'(err_cnt - e0), 32'd1);
        check("bad_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset mid-load, then a fresh load from address 0.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h4C);
        for (int i = 0; i < 10; i++) send(8'h6F);
        reset_dut(2);
        send(8'h4C);
        for (int i = 0; i < NCELL; i++) send(8'h2E);
        drain();
        check("rst_reload_done", 32'(done_cnt - d0), 32'd1);
        check("rst_reload_err", 32'(err_cnt - e0), 32'd0);

`ifdef BOARD_LOADER_ECHO_EN
        // Echo back-pressure.
        tx_hold = 22;
        send(8'h4C);
        repeat (20) begin
            @(negedge clk);
            if (tx_hold > 0) begin
                check("hold_tx_valid", 32'(bus.tx_valid), 32'd1);
                check("hold_tx_data", 32'(bus.tx_data), 32'h4C);
                check("hold_rx_ready", 32'(bus.rx_ready), 32'd0);
            end
        end
        for (int i = 0; i < NCELL; i++) send(8'h4F);
        drain();
`endif

        // Randomized streams.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (!m_loading && r < 50) b = 8'h4C;
            else if (r < 55) begin
                case ($urandom_range(0, 5))
                    0: b = 8'h4F; 1: b = 8'h6F; 2: b = 8'h31;
                    3: b = 8'h20; 4: b = 8'h2E; default: b = 8'h30;
                endcase
            end else if (r < 70) b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
            else if (r < 74) b = 8'h4C;
            else if (r < 77) b = 8'h1B;
            else if (r < 85) b = 8'h4F;
            else b = 8'($urandom_range(0, 255));
            send(b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

`ifdef BOARD_LOADER_ECHO_EN
        repeat (60) @(negedge clk);
        check("echo_drained", 32'(echo_q.size()), 32'd0);
`else
        check("tx_constant_zero", 32'(tx_bad), 32'd0);
`endif

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end
endmodule
